mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, is the multiplier operand width and the iteration count (legal range 2..32).
REQ-002 clk  input  1  Single clock; all state changes on rising edge.
REQ-003 reset  input  1  Asynchronous, active-low reset (0 = reset asserted).
REQ-004 inputdata_ready  input  1  Operands valid on datapath inputs; start request.
REQ-005 mplr_lsb  input  1  Current LSB of datapath multiplier shift register.
REQ-006 abort  input  1  Synchronous cancel of an operation in progress.
REQ-007 result_ack  input  1  Consumer has taken the product.
REQ-008 loaddata  output  1  Datapath loads operands and clears accumulator.
REQ-009 add_en  output  1  Datapath adds multiplicand into accumulator this cycle.
REQ-010 shift_en  output  1  Datapath shifts accumulator/multiplier this cycle.
REQ-011 count  output  $clog2(WIDTH)  Current iteration index.
REQ-012 busy  output  1  Operation in progress (LOAD or CALC).
REQ-013 done  output  1  Product valid on datapath output.

Function
REQ-014 The block SHALL implement a four-state FSM: IDLE, LOAD, CALC, DONE, with a registered state and a registered count.
REQ-015 IDLE: inputdata_ready=1 -> LOAD; else stay IDLE.
REQ-016 LOAD: loaddata=1 for exactly one cycle; count cleared to 0; unconditional -> CALC (abort ignored here).
REQ-017 CALC: shift_en=1 every cycle; add_en=mplr_lsb (combinational, CALC only); count increments by 1 per cycle.
REQ-018 CALC exit: when count==WIDTH-1 and abort=0 -> DONE; count is not incremented past WIDTH-1 (no wrap).
REQ-019 CALC with abort=1: -> IDLE next cycle; shift_en and add_en forced to 0 in that cycle; done never asserted for that operation.
REQ-020 DONE: done=1 held every cycle until result_ack=1, then -> IDLE; count holds WIDTH-1.
REQ-021 result_ack outside DONE SHALL be ignored; inputdata_ready outside IDLE SHALL be ignored (no queuing).
REQ-022 inputdata_ready=1 and result_ack=1 in the same DONE cycle: -> IDLE only; new operation starts when inputdata_ready is seen in IDLE.
REQ-023 busy=1 in LOAD and CALC only; loaddata, shift_en, add_en, done SHALL be 0 in all states other than those stated.
REQ-024 Latency: inputdata_ready sampled in cycle N -> loaddata in N+1 -> shift_en in N+2..N+WIDTH+1 -> done from N+WIDTH+2.
REQ-025 Illegal/unused state encodings SHALL return to IDLE on the next clock.

Reset
REQ-026 reset=0 SHALL immediately (without clock) force state=IDLE and count=0, and hence loaddata=0, add_en=0, shift_en=0, busy=0, done=0.
REQ-027 reset asserted mid-CALC or in DONE SHALL discard the operation; after release the block waits in IDLE for a new inputdata_ready.
REQ-028 First possible transition after reset release is on the first rising clk edge with reset=1.

Verification
REQ-029 WIDTH=8, inputdata_ready pulse at cycle 0 -> loaddata=1 cycle 1, shift_en=1 cycles 2-9 with count 0..7, done=1 from cycle 10.
REQ-030 mplr_lsb driven per cycle with pattern of 0xA5 (LSB first) during CALC -> add_en sequence 1,0,1,0,0,1,0,1.
REQ-031 Hold result_ack=0 for 5 cycles in DONE -> done stays 1, count stays 7; result_ack=1 -> IDLE next cycle, done=0.
REQ-032 abort=1 at count=3 -> IDLE next cycle, shift_en=0 in abort cycle, done never rises; subsequent start runs full 8 iterations.
REQ-033 inputdata_ready held high throughout -> back-to-back operations, each with exactly one loaddata pulse and 8 shift_en cycles; starts during busy/done not counted.
REQ-034 reset=0 asynchronously at count=5 -> all outputs 0 before next clk edge; after release no activity until inputdata_ready=1.

Source files
------------

// File: rtl/mult_sequencer.sv
// Control FSM for a shift-add sequential multiplier: IDLE -> LOAD -> CALC (WIDTH iterations) -> DONE.
// Latency: loaddata one cycle after start, WIDTH shift cycles, done held until result_ack; no backpressure beyond result_ack.
module mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inputdata_ready,
  input  logic                     mplr_lsb,
  input  logic                     abort,
  input  logic                     result_ack,
  output logic                     loaddata,
  output logic                     add_en,
  output logic                     shift_en,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CALC = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    count_nxt = count;
    loaddata  = 1'b0;
    add_en    = 1'b0;
    shift_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (inputdata_ready) begin
          state_nxt = LOAD;
          count_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        loaddata  = 1'b1;
        busy      = 1'b1;
        count_nxt = '0;
        state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        // abort suppresses datapath activity in the cycle it is seen
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          shift_en = 1'b1;
          add_en   = mplr_lsb;
          if (count == LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = CALC;
            count_nxt = count + 1'b1;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = result_ack ? IDLE : DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: fixed vector table, directed abort/reset/back-to-back sequences, random run vs. model.
module tb_mult_sequencer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  logic inputdata_ready, mplr_lsb, abort, result_ack;
  logic loaddata, add_en, shift_en, busy, done;
  logic [$clog2(W)-1:0] count;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .inputdata_ready (inputdata_ready),
    .mplr_lsb        (mplr_lsb),
    .abort           (abort),
    .result_ack      (result_ack),
    .loaddata        (loaddata),
    .add_en          (add_en),
    .shift_en        (shift_en),
    .count           (count),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ir, lsb, ab, ack;
    logic ld, sh, ad, bz, dn;
    int   cnt;  // -1: not checked
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Model: t = cycles since the operation's LOAD cycle (-1 when idle).
  int t = -1;
  int exp_cnt = 0;
  bit cnt_known = 1'b1;

  int n_load, n_shift, n_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_expect(input logic lsb, input logic ab, output vec_t e);
    e = '{ir:0, lsb:lsb, ab:ab, ack:0, ld:0, sh:0, ad:0, bz:0, dn:0, cnt:-1};
    if (t < 0) begin
      e.cnt = cnt_known ? exp_cnt : -1;
    end else if (t == 0) begin
      e.ld = 1; e.bz = 1;
    end else if (t <= W) begin
      e.bz = 1; e.sh = !ab; e.ad = !ab && lsb; e.cnt = t - 1;
    end else begin
      e.dn = 1; e.cnt = W - 1;
    end
  endtask

  task automatic model_step(input logic ir, input logic ab, input logic ack);
    if (t < 0) begin
      if (ir) begin t = 0; cnt_known = 1'b0; end
    end else if (t == 0) begin
      t = 1;
    end else if (t <= W) begin
      t = ab ? -1 : t + 1;
    end else if (ack) begin
      t = -1;
    end
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic cycle(input logic ir, input logic lsb, input logic ab, input logic ack,
                       input bit use_tbl, input vec_t tv, input string tag);
    vec_t e;
    inputdata_ready = ir; mplr_lsb = lsb; abort = ab; result_ack = ack;
    @(negedge clk);
    if (use_tbl) e = tv; else model_expect(lsb, ab, e);
    chk({tag, ".ctl"}, {27'd0, loaddata, shift_en, add_en, busy, done},
        {27'd0, e.ld, e.sh, e.ad, e.bz, e.dn});
    if (e.cnt >= 0) chk({tag, ".count"}, int'(count), e.cnt);
    n_load  += int'(loaddata);
    n_shift += int'(shift_en);
    n_done  += int'(done);
    @(posedge clk);
    model_step(ir, ab, ack);
    #1;
  endtask

  task automatic mcycle(input logic ir, input logic lsb, input logic ab, input logic ack,
                        input string tag);
    vec_t dummy;
    dummy = '{ir:0, lsb:0, ab:0, ack:0, ld:0, sh:0, ad:0, bz:0, dn:0, cnt:-1};
    cycle(ir, lsb, ab, ack, 1'b0, dummy, tag);
  endtask

  vec_t tbl[$];
  logic [7:0] pat;

  initial begin
    vec_t v;
    reset = 1'b0;
    inputdata_ready = 0; mplr_lsb = 0; abort = 0; result_ack = 0;
    n_load = 0; n_shift = 0; n_done = 0;

    // Start pulse, 0xA5 multiplier bits, 5 waiting cycles in DONE, then ack.
    pat = 8'hA5;
    tbl.push_back('{ir:1, lsb:0, ab:0, ack:0, ld:0, sh:0, ad:0, bz:0, dn:0, cnt:0});
    tbl.push_back('{ir:0, lsb:0, ab:0, ack:0, ld:1, sh:0, ad:0, bz:1, dn:0, cnt:-1});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{ir:0, lsb:pat[i], ab:0, ack:0, ld:0, sh:1, ad:pat[i], bz:1, dn:0, cnt:i});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{ir:0, lsb:0, ab:0, ack:0, ld:0, sh:0, ad:0, bz:0, dn:1, cnt:7});
    tbl.push_back('{ir:0, lsb:0, ab:0, ack:1, ld:0, sh:0, ad:0, bz:0, dn:1, cnt:7});
    tbl.push_back('{ir:0, lsb:0, ab:0, ack:0, ld:0, sh:0, ad:0, bz:0, dn:0, cnt:-1});

    #12;
    chk("reset.ctl", {27'd0, loaddata, shift_en, add_en, busy, done}, 0);
    chk("reset.count", int'(count), 0);
    #11 reset = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      v = tbl[i];
      cycle(v.ir, v.lsb, v.ab, v.ack, 1'b1, v, $sformatf("tbl%0d", i));
    end

    // Abort at count 3: no done for that operation, then a full run.
    n_done = 0; n_shift = 0;
    mcycle(1, 0, 0, 0, "ab.start");
    mcycle(0, 0, 0, 0, "ab.load");
    for (int i = 0; i < 3; i++) mcycle(0, 1, 0, 0, "ab.calc");
    inputdata_ready = 0; mplr_lsb = 1; abort = 1;
    @(negedge clk);
    chk("ab.count3", int'(count), 3);
    chk("ab.shift_off", {30'd0, shift_en, add_en}, 0);
    @(posedge clk); model_step(0, 1, 0); #1;
    abort = 0;
    for (int i = 0; i < 4; i++) mcycle(0, 0, 0, 1, "ab.idle");
    chk("ab.no_done", n_done, 0);
    chk("ab.busy_after", int'(busy), 0);
    n_shift = 0;
    mcycle(1, 0, 0, 0, "ab2.start");
    for (int i = 0; i < W + 1; i++) mcycle(0, i[0], 0, 0, "ab2.run");
    mcycle(0, 0, 0, 1, "ab2.ack");
    chk("ab2.shifts", n_shift, W);
    mcycle(0, 0, 0, 0, "ab2.idle");

    // inputdata_ready held high: three complete operations in 33 cycles.
    n_load = 0; n_shift = 0;
    for (int i = 0; i < 3 * (W + 3); i++) mcycle(1, 1'($urandom), 0, 1, "b2b");
    chk("b2b.loads", n_load, 3);
    chk("b2b.shifts", n_shift, 3 * W);
    inputdata_ready = 0; result_ack = 0;
    while (t >= 0) mcycle(0, 0, 0, 1, "b2b.drain");

    // Asynchronous reset at count 5.
    mcycle(1, 0, 0, 0, "rst.start");
    for (int i = 0; i < 6; i++) mcycle(0, 1, 0, 0, "rst.run");
    chk("rst.count5", int'(count), 5);
    inputdata_ready = 0; mplr_lsb = 1;
    #2 reset = 1'b0;
    #1;
    chk("rst.async_ctl", {27'd0, loaddata, shift_en, add_en, busy, done}, 0);
    chk("rst.async_count", int'(count), 0);
    t = -1; exp_cnt = 0; cnt_known = 1'b1;
    @(negedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    n_load = 0;
    for (int i = 0; i < 5; i++) mcycle(0, 1, 0, 1, "rst.quiet");
    chk("rst.no_load", n_load, 0);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++)
      mcycle(($urandom_range(3) == 0), 1'($urandom), ($urandom_range(19) == 0),
             ($urandom_range(2) == 0), "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
